mdiv_iter: RTL and testbench

Parametrised iterative integer divider producing quotient and remainder for signed or unsigned operands at 1 or 2 quotient bits per cycle. Successor to the fixed 32-bit radix-4 divide datapath in the multiply/divide unit: it owns its own sequencer, start/done handshake, kill, divide-by-zero flag and optional early-out. It sits behind the HI/LO register file and drives sign-extended results on the same WIDTH+EXT bus format.

---
 rtl/mdiv_pkg.sv | 25 ++
 rtl/mdiv_digit_sel.sv | 55 +++++
 rtl/mdiv_iter.sv | 177 +++++++++++++++++
 tb/tb_mdiv_iter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdiv_pkg
//  Description : Shared types and helpers for the mdiv_iter iterative divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdiv_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Iteration counter must be able to hold the full iteration count N.
    function automatic int cnt_w(input int width, input int radix_log2);
        return $clog2(width / radix_log2 + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdiv_digit_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mdiv_digit_sel
//  Description : One restoring-division step: shift in dividend bits, trial
//                subtract the divisor multiples, pick the quotient digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdiv_digit_sel #(
    parameter int WIDTH      = 32,
    parameter int RADIX_LOG2 = 2
) (
    input  logic [WIDTH-1:0]      i_pr,
    input  logic [RADIX_LOG2-1:0] i_qbits,
    input  logic [WIDTH-1:0]      i_dvsr,
    output logic [RADIX_LOG2-1:0] o_digit,
    output logic [WIDTH-1:0]      o_pr_nxt
);

    generate
        if (RADIX_LOG2 == 2) begin : g_radix4
            logic [WIDTH+1:0] w_sh;
            logic [WIDTH+1:0] w_d1;
            logic [WIDTH+1:0] w_d2;
            logic [WIDTH+1:0] w_d3;
            logic             w_ge1;
            logic             w_ge2;
            logic             w_ge3;

            assign w_sh  = {i_pr, i_qbits};
            assign w_d1  = {2'b00, i_dvsr};
            assign w_d2  = {1'b0, i_dvsr, 1'b0};
            assign w_d3  = w_d1 + w_d2;
            assign w_ge1 = (w_sh >= w_d1);
            assign w_ge2 = (w_sh >= w_d2);
            assign w_ge3 = (w_sh >= w_d3);

            // Selected difference is below the divisor, so the low WIDTH bits are exact.
            assign o_digit  = w_ge3 ? 2'd3 : w_ge2 ? 2'd2 : w_ge1 ? 2'd1 : 2'd0;
            assign o_pr_nxt = w_ge3 ? (w_sh[WIDTH-1:0] - w_d3[WIDTH-1:0]) :
                              w_ge2 ? (w_sh[WIDTH-1:0] - w_d2[WIDTH-1:0]) :
                              w_ge1 ? (w_sh[WIDTH-1:0] - w_d1[WIDTH-1:0]) :
                                       w_sh[WIDTH-1:0];
        end else begin : g_radix2
            logic [WIDTH:0] w_sh;
            logic           w_ge;

            assign w_sh     = {i_pr, i_qbits};
            assign w_ge     = (w_sh >= {1'b0, i_dvsr});
            assign o_digit  = w_ge;
            assign o_pr_nxt = w_ge ? (w_sh[WIDTH-1:0] - i_dvsr) : w_sh[WIDTH-1:0];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdiv_iter
//  Description : Iterative signed/unsigned divider, 1 or 2 quotient bits per
//                cycle, with kill, divide-by-zero flag and extended results.
//                Optional early-out for short dividends: MDIV_EARLY_OUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdiv_iter
    import mdiv_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int RADIX_LOG2 = 2,
    parameter int EXT        = 8
) (
    input  logic                 CLK,
    input  logic                 RESET_D2_R_N,
    input  logic                 START,
    input  logic                 KILL,
    input  logic                 DIV_SIGNED,
    input  logic [WIDTH-1:0]     DEND,
    input  logic [WIDTH-1:0]     DVSR,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 DBZ,
    output logic [WIDTH+EXT-1:0] QUOT,
    output logic [WIDTH+EXT-1:0] REM
);

    localparam int                 c_CNT_W     = cnt_w(WIDTH, RADIX_LOG2);
    localparam int                 c_HALF_BITS = WIDTH / 2;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(WIDTH / RADIX_LOG2);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF  = c_CNT_W'(c_HALF_BITS / RADIX_LOG2);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_signed;
    logic                   r_dend_neg;
    logic                   r_quot_neg;
    logic                   r_dbz;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_d;
    logic [WIDTH-1:0]       r_pr;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [WIDTH+EXT-1:0]   r_quot;
    logic [WIDTH+EXT-1:0]   r_rem;
    logic                   r_dbz_out;

    logic                   w_accept;
    logic                   w_load_out;
    logic                   w_dend_neg;
    logic                   w_dvsr_neg;
    logic [WIDTH-1:0]       w_dend_mag;
    logic [WIDTH-1:0]       w_dvsr_mag;
    logic                   w_eo;
    logic [RADIX_LOG2-1:0]  w_digit;
    logic [WIDTH-1:0]       w_pr_nxt;
    logic [WIDTH-1:0]       w_quot_fix;
    logic [WIDTH-1:0]       w_rem_fix;

    // r_q holds the raw dividend in PREP, then doubles as dividend/quotient shifter.
    assign w_dend_neg = r_signed & r_q[WIDTH-1];
    assign w_dvsr_neg = r_signed & r_d[WIDTH-1];
    assign w_dend_mag = w_dend_neg ? -r_q : r_q;
    assign w_dvsr_mag = w_dvsr_neg ? -r_d : r_d;

`ifdef MDIV_EARLY_OUT_EN
    localparam bit c_EO_OK = ((c_HALF_BITS % RADIX_LOG2) == 0);
    assign w_eo = c_EO_OK && (w_dend_mag[WIDTH-1:c_HALF_BITS] == '0);
`else
    assign w_eo = 1'b0;
`endif

    mdiv_digit_sel #(
        .WIDTH      (WIDTH),
        .RADIX_LOG2 (RADIX_LOG2)
    ) u_digit_sel (
        .i_pr     (r_pr),
        .i_qbits  (r_q[WIDTH-1 -: RADIX_LOG2]),
        .i_dvsr   (r_d),
        .o_digit  (w_digit),
        .o_pr_nxt (w_pr_nxt)
    );

    assign w_quot_fix = r_dbz ? '1 : (r_quot_neg ? -r_q : r_q);
    assign w_rem_fix  = r_dend_neg ? -r_pr : r_pr;

    assign w_accept   = (r_state == ST_IDLE) & START & ~KILL;
    assign w_load_out = (r_state == ST_FIX) & ~KILL;

    always_ff @(posedge CLK or negedge RESET_D2_R_N) begin
        if (!RESET_D2_R_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (START && !KILL) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = KILL ? ST_IDLE : ST_ITER;
            ST_ITER: begin
                if (KILL)                     w_state_nxt = ST_IDLE;
                else if (r_cnt == c_CNT_ONE)  w_state_nxt = ST_FIX;
            end
            ST_FIX:  w_state_nxt = KILL ? ST_IDLE : ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_D2_R_N) begin
        if (!RESET_D2_R_N) begin
            r_signed   <= 1'b0;
            r_dend_neg <= 1'b0;
            r_quot_neg <= 1'b0;
            r_dbz      <= 1'b0;
            r_q        <= '0;
            r_d        <= '0;
            r_pr       <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz_out  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_q      <= DEND;
                        r_d      <= DVSR;
                        r_signed <= DIV_SIGNED;
                    end
                end
                ST_PREP: begin
                    r_d        <= w_dvsr_mag;
                    r_pr       <= '0;
                    r_dend_neg <= w_dend_neg;
                    r_quot_neg <= w_dend_neg ^ w_dvsr_neg;
                    r_dbz      <= (r_d == '0);
                    if (w_eo) begin
                        r_q   <= w_dend_mag << c_HALF_BITS;
                        r_cnt <= c_CNT_HALF;
                    end else begin
                        r_q   <= w_dend_mag;
                        r_cnt <= c_CNT_FULL;
                    end
                end
                ST_ITER: begin
                    r_q   <= {r_q[WIDTH-RADIX_LOG2-1:0], w_digit};
                    r_pr  <= w_pr_nxt;
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                ST_FIX: begin
                    // Result buses only move on the edge into DONE; a kill here leaves them alone.
                    if (w_load_out) begin
                        r_quot    <= {{EXT{r_signed & w_quot_fix[WIDTH-1]}}, w_quot_fix};
                        r_rem     <= {{EXT{r_signed & w_rem_fix[WIDTH-1]}}, w_rem_fix};
                        r_dbz_out <= r_dbz;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign BUSY = (r_state != ST_IDLE);
    assign DONE = (r_state == ST_DONE);
    assign DBZ  = r_dbz_out;
    assign QUOT = r_quot;
    assign REM  = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_mdiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdiv_iter
//  Description : Scoreboard bench for mdiv_iter (32-bit radix-4 and 16-bit
//                radix-2 instances); honours MDIV_EARLY_OUT_EN latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdiv_iter;

    localparam int c_LAT_A = 19;
    localparam int c_LAT_B = 19;
`ifdef MDIV_EARLY_OUT_EN
    localparam int c_LAT_EO_A = 11;
    localparam int c_LAT_EO_B = 11;
`else
    localparam int c_LAT_EO_A = 19;
    localparam int c_LAT_EO_B = 19;
`endif

    typedef struct {
        logic [39:0] q;
        logic [39:0] r;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    exp_t        qa[$];
    exp_t        qb[$];

    logic        a_start, a_kill, a_signed, a_busy, a_done, a_dbz;
    logic [31:0] a_dend, a_dvsr;
    logic [39:0] a_quot, a_rem;
    logic        b_start, b_kill, b_signed, b_busy, b_done, b_dbz;
    logic [15:0] b_dend, b_dvsr;
    logic [23:0] b_quot, b_rem;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdiv_iter #(.WIDTH(32), .RADIX_LOG2(2), .EXT(8)) u_dut_a (
        .CLK(clk), .RESET_D2_R_N(rst_n), .START(a_start), .KILL(a_kill),
        .DIV_SIGNED(a_signed), .DEND(a_dend), .DVSR(a_dvsr), .BUSY(a_busy),
        .DONE(a_done), .DBZ(a_dbz), .QUOT(a_quot), .REM(a_rem)
    );

    mdiv_iter #(.WIDTH(16), .RADIX_LOG2(1), .EXT(8)) u_dut_b (
        .CLK(clk), .RESET_D2_R_N(rst_n), .START(b_start), .KILL(b_kill),
        .DIV_SIGNED(b_signed), .DEND(b_dend), .DVSR(b_dvsr), .BUSY(b_busy),
        .DONE(b_done), .DBZ(b_dbz), .QUOT(b_quot), .REM(b_rem)
    );

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n === 1'b1 && a_done === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_done", 40'(a_done), 40'd0);
            end else begin
                e = qa.pop_front();
                chk("a_quot", a_quot, e.q);
                chk("a_rem", a_rem, e.r);
                chk("a_dbz", 40'(a_dbz), 40'(e.dbz));
                chk("a_done_cycle", 40'(cyc), 40'(e.done_cyc));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n === 1'b1 && b_done === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_done", 40'(b_done), 40'd0);
            end else begin
                e = qb.pop_front();
                chk("b_quot", 40'(b_quot), e.q);
                chk("b_rem", 40'(b_rem), e.r);
                chk("b_dbz", 40'(b_dbz), 40'(e.dbz));
                chk("b_done_cycle", 40'(cyc), 40'(e.done_cyc));
            end
        end
    end

    task automatic drain(input bit use_b);
        int t = 0;
        while (((use_b ? qb.size() : qa.size()) != 0) && t < 60) begin
            @(negedge clk);
            t++;
        end
        if ((use_b ? qb.size() : qa.size()) != 0) begin
            chk(use_b ? "b_timeout" : "a_timeout", 40'd1, 40'd0);
            if (use_b) qb.delete(); else qa.delete();
        end
    endtask

    task automatic issue(input bit use_b, input logic sgn, input logic [31:0] dd,
                         input logic [31:0] dv, input logic [39:0] eq, input logic [39:0] er,
                         input logic edbz, input int lat);
        exp_t e;
        @(negedge clk);
        e.q = eq; e.r = er; e.dbz = edbz; e.done_cyc = cyc + lat;
        if (use_b) begin
            b_start = 1'b1; b_signed = sgn; b_dend = dd[15:0]; b_dvsr = dv[15:0];
            qb.push_back(e);
        end else begin
            a_start = 1'b1; a_signed = sgn; a_dend = dd; a_dvsr = dv;
            qa.push_back(e);
        end
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        a_dend = ~a_dend; a_dvsr = ~a_dvsr; b_dend = ~b_dend; b_dvsr = ~b_dvsr;
    endtask

    task automatic op(input bit use_b, input logic sgn, input logic [31:0] dd,
                      input logic [31:0] dv, input logic [39:0] eq, input logic [39:0] er,
                      input logic edbz, input int lat);
        issue(use_b, sgn, dd, dv, eq, er, edbz, lat);
        drain(use_b);
    endtask

    initial begin : stim
        int a0;
        rst_n = 1'b0;
        a_start = 0; a_kill = 0; a_signed = 0; a_dend = '0; a_dvsr = '0;
        b_start = 0; b_kill = 0; b_signed = 0; b_dend = '0; b_dvsr = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 40'(a_busy), 40'd0);
        chk("rst_done", 40'(a_done), 40'd0);
        chk("rst_dbz", 40'(a_dbz), 40'd0);
        chk("rst_quot", a_quot, 40'd0);
        chk("rst_rem", a_rem, 40'd0);
        rst_n = 1'b1;

        op(0, 0, 32'd100,       32'd7,          40'h00_0000_000E, 40'h00_0000_0002, 0, c_LAT_EO_A);
        op(0, 1, 32'hFFFF_FF9C, 32'd7,          40'hFF_FFFF_FFF2, 40'hFF_FFFF_FFFE, 0, c_LAT_EO_A);
        op(0, 1, 32'd100,       32'hFFFF_FFF9,  40'hFF_FFFF_FFF2, 40'h00_0000_0002, 0, c_LAT_EO_A);
        op(0, 0, 32'hFFFF_FF9C, 32'd7,          40'h00_2492_4916, 40'h00_0000_0002, 0, c_LAT_A);
        op(0, 0, 32'h1234_5678, 32'd0,          40'h00_FFFF_FFFF, 40'h00_1234_5678, 1, c_LAT_A);
        op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF,  40'hFF_8000_0000, 40'h00_0000_0000, 0, c_LAT_A);
        op(0, 0, 32'h8000_0000, 32'd3,          40'h00_2AAA_AAAA, 40'h00_0000_0002, 0, c_LAT_A);
        op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  40'h00_0000_0001, 40'h00_0000_0000, 0, c_LAT_A);
        op(0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFE,  40'h00_0000_0003, 40'hFF_FFFF_FFFF, 0, c_LAT_EO_A);
        op(0, 0, 32'd5,         32'd9,          40'h00_0000_0000, 40'h00_0000_0005, 0, c_LAT_EO_A);

        // START while busy must not disturb the running divide
        issue(0, 0, 32'd100, 32'd7, 40'h00_0000_000E, 40'h00_0000_0002, 0, c_LAT_EO_A);
        @(negedge clk);
        a_start = 1'b1; a_signed = 1'b1; a_dend = 32'h0000_1000; a_dvsr = 32'd1;
        @(negedge clk);
        a_start = 1'b0;
        drain(0);

        // KILL together with START in IDLE is not an accept
        @(negedge clk);
        a_start = 1'b1; a_kill = 1'b1; a_dend = 32'd9; a_dvsr = 32'd3;
        @(negedge clk);
        a_start = 1'b0; a_kill = 1'b0;
        chk("kill_start_idle_busy", 40'(a_busy), 40'd0);

        op(0, 1, 32'hFFFF_FFFB, 32'd0, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFB, 1, c_LAT_EO_A);

        // KILL in ITER cycle 5
        @(negedge clk);
        a0 = cyc;
        a_start = 1'b1; a_signed = 1'b0; a_dend = 32'd100; a_dvsr = 32'd7;
        @(negedge clk);
        a_start = 1'b0;
        while (cyc < a0 + 5) @(negedge clk);
        a_kill = 1'b1;
        @(negedge clk);
        a_kill = 1'b0;
        chk("kill_busy", 40'(a_busy), 40'd0);
        chk("kill_quot_held", a_quot, 40'hFF_FFFF_FFFF);
        chk("kill_rem_held", a_rem, 40'hFF_FFFF_FFFB);
        chk("kill_dbz_held", 40'(a_dbz), 40'd1);
        repeat (25) @(negedge clk);
        op(0, 0, 32'd7, 32'd2, 40'h00_0000_0003, 40'h00_0000_0001, 0, c_LAT_EO_A);

        // Reset mid-operation: clears results, no DONE
        @(negedge clk);
        a_start = 1'b1; a_signed = 1'b0; a_dend = 32'hFFFF_0000; a_dvsr = 32'd5;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 40'(a_busy), 40'd0);
        chk("midrst_quot", a_quot, 40'd0);
        chk("midrst_rem", a_rem, 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);

        op(1, 0, 32'h0000_00FF, 32'h0000_0003, 40'h00_0000_0055, 40'h00_0000_0000, 0, c_LAT_EO_B);
        op(1, 1, 32'h0000_8000, 32'h0000_0007, 40'h00_00FF_EDB7, 40'h00_00FF_FFFF, 0, c_LAT_B);
        op(1, 0, 32'h0000_FFFF, 32'h0000_00FF, 40'h00_0000_0101, 40'h00_0000_0000, 0, c_LAT_B);
        op(1, 0, 32'h0000_1234, 32'h0000_0000, 40'h00_0000_FFFF, 40'h00_0000_1234, 1, c_LAT_B);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
